// File: rtl/mem_io_pkg.sv
// mem_io_pkg: shared region codes, timer offsets, control bit indices and timer FSM states
//   Region codes select the block by ADDR[15:12]; timer offsets select a register by ADDR[1:0].
package mem_io_pkg;
    localparam logic [3:0] REG_RAM = 4'h0;
    localparam logic [3:0] REG_LED = 4'h1;
    localparam logic [3:0] REG_SW  = 4'h3;
    localparam logic [3:0] REG_TMR = 4'h5;
    localparam logic [1:0] T_CTRL  = 2'd0;
    localparam logic [1:0] T_LOAD  = 2'd1;
    localparam logic [1:0] T_COUNT = 2'd2;
    localparam logic [1:0] T_STAT  = 2'd3;
    localparam int CTRL_EN   = 0;
    localparam int CTRL_AUTO = 1;
    typedef enum logic {T_IDLE, T_RUN} tstate_e;
endpackage

// File: rtl/resp_timer.sv
// resp_timer: interval timer with CTRL/LOAD/COUNT/STAT registers, only built with MEM_IO_TIMER_EN
//   clock_i   system clock, rising edge
//   resetn_i  synchronous active-low reset
//   sel_i     ADDR selects the timer region this cycle (counts as a read every cycle)
//   w_i       write strobe
//   off_i     register offset ADDR[1:0]
//   wdata_i   write data
//   rdata_o   combinational read data of the selected register
//   tf_o      timer flag TF
`ifdef MEM_IO_TIMER_EN
module resp_timer
    import mem_io_pkg::*;
(
    input  logic        clock_i,
    input  logic        resetn_i,
    input  logic        sel_i,
    input  logic        w_i,
    input  logic [1:0]  off_i,
    input  logic [15:0] wdata_i,
    output logic [15:0] rdata_o,
    output logic        tf_o
);
    tstate_e     state_q, state_d;
    logic        auto_q, auto_d, tf_q, tf_d;
    logic [15:0] load_q, load_d, count_q, count_d;
    logic        wr_ctrl, wr_load, run, expire;

    assign wr_ctrl = sel_i && w_i && off_i == T_CTRL;
    assign wr_load = sel_i && w_i && off_i == T_LOAD;
    assign run     = state_q == T_RUN;
    assign expire  = run && count_q == 16'd0;
    assign tf_o    = tf_q;

    always_ff @(posedge clock_i) begin
        state_q <= !resetn_i ? T_IDLE : state_d;
    end

    // EN is the FSM state itself, so a CTRL write decides the state outright.
    always_comb begin
        state_d = wr_ctrl ? (wdata_i[CTRL_EN] ? T_RUN : T_IDLE)
                : (expire && !auto_q) ? T_IDLE : state_q;
    end

    // Leaving RUN (EN cleared or one-shot expiry) freezes COUNT; expiry never wraps.
    always_comb begin
        auto_d  = wr_ctrl ? wdata_i[CTRL_AUTO] : auto_q;
        load_d  = wr_load ? wdata_i : load_q;
        count_d = !run ? (state_d == T_RUN ? load_q : count_q)
                : state_d == T_IDLE ? count_q
                : expire ? (auto_q ? load_q : count_q)
                : count_q - 16'd1;
        tf_d    = expire ? 1'b1 : (sel_i && off_i == T_STAT) ? 1'b0 : tf_q;
        rdata_o = off_i == T_CTRL  ? {14'h0, auto_q, run}
                : off_i == T_LOAD  ? load_q
                : off_i == T_COUNT ? count_q
                : {15'h0, tf_q};
    end

    always_ff @(posedge clock_i) begin
        if (!resetn_i) begin
            auto_q  <= 1'b0;
            load_q  <= 16'h0;
            count_q <= 16'h0;
            tf_q    <= 1'b0;
        end else begin
            auto_q  <= auto_d;
            load_q  <= load_d;
            count_q <= count_d;
            tf_q    <= tf_d;
        end
    end
endmodule
`endif

// File: rtl/mem_io_responder.sv
// mem_io_responder: memory-port responder decoding RAM, LED register, switches and optional timer (MEM_IO_TIMER_EN)
//   clock_i   system clock, rising edge
//   resetn_i  synchronous active-low reset
//   addr_i    word address from processor
//   dout_i    write data from processor
//   w_i       write strobe
//   din_o     registered read data, one cycle after addr_i
//   sw_i      asynchronous switch inputs
//   ledr_o    LED register
//   irq_t_o   timer flag (tied 0 without MEM_IO_TIMER_EN)
module mem_io_responder
    import mem_io_pkg::*;
#(
    parameter int RAM_AW = 8,
    parameter int LED_W  = 10,
    parameter int SW_W   = 10
) (
    input  logic             clock_i,
    input  logic             resetn_i,
    input  logic [15:0]      addr_i,
    input  logic [15:0]      dout_i,
    input  logic             w_i,
    output logic [15:0]      din_o,
    input  logic [SW_W-1:0]  sw_i,
    output logic [LED_W-1:0] ledr_o,
    output logic             irq_t_o
);
    logic [3:0]       region;
    logic [15:0]      ram_q [2**RAM_AW];
    logic [LED_W-1:0] led_q, led_d;
    logic [SW_W-1:0]  sw_meta_q, sw_q;
    logic [15:0]      din_q, din_d, tmr_rdata;
    logic             unused_addr;

    assign region      = addr_i[15:12];
    assign unused_addr = ^addr_i;
    assign din_o       = din_q;
    assign ledr_o      = led_q;

    // RAM has no reset; its nonblocking write keeps same-edge reads returning old data.
    always_ff @(posedge clock_i) begin
        if (w_i && region == REG_RAM) ram_q[addr_i[RAM_AW-1:0]] <= dout_i;
    end

    always_comb begin
        led_d = (w_i && region == REG_LED) ? dout_i[LED_W-1:0] : led_q;
        din_d = region == REG_RAM ? ram_q[addr_i[RAM_AW-1:0]]
              : region == REG_LED ? 16'(led_q)
              : region == REG_SW  ? 16'(sw_q)
              : region == REG_TMR ? tmr_rdata
              : 16'h0;
    end

    always_ff @(posedge clock_i) begin
        if (!resetn_i) begin
            led_q     <= '0;
            sw_meta_q <= '0;
            sw_q      <= '0;
            din_q     <= 16'h0;
        end else begin
            led_q     <= led_d;
            sw_meta_q <= sw_i;
            sw_q      <= sw_meta_q;
            din_q     <= din_d;
        end
    end

`ifdef MEM_IO_TIMER_EN
    resp_timer u_timer (
        .clock_i (clock_i),
        .resetn_i(resetn_i),
        .sel_i   (region == REG_TMR),
        .w_i     (w_i),
        .off_i   (addr_i[1:0]),
        .wdata_i (dout_i),
        .rdata_o (tmr_rdata),
        .tf_o    (irq_t_o)
    );
`else
    assign tmr_rdata = 16'h0;
    assign irq_t_o   = 1'b0;
`endif
endmodule
